// File: rtl/vram_rd_arbiter_pkg.sv
// Shared encodings for the VRAM read arbiter: owner IDs, FSM states, window prefix.
package vram_arb_pkg;

    localparam logic       ID_DISP     = 1'b0;
    localparam logic       ID_AUX      = 1'b1;
    localparam logic [2:0] VRAM_PREFIX = 3'b001;
    localparam int         CNT_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vram_rd_arbiter_if.sv
// Requester-side and interconnect-side AR/R handshake bundle for the VRAM read arbiter.
interface vram_rd_arbiter_if #(
    parameter int C_ADDR_WIDTH = 29
);
    logic [C_ADDR_WIDTH-1:0] M0_ARADDR;
    logic                    M0_ARVALID;
    logic                    M0_ARREADY;
    logic                    M0_RVALID;
    logic                    M0_RREADY;
    logic [C_ADDR_WIDTH-1:0] M1_ARADDR;
    logic                    M1_ARVALID;
    logic                    M1_ARREADY;
    logic                    M1_RVALID;
    logic                    M1_RREADY;

    logic                    M_AXI_ARID;
    logic [31:0]             M_AXI_ARADDR;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic                    M_AXI_RID;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RLAST;
    logic                    M_AXI_RREADY;

    // Arbiter side
    modport slave (
        input  M0_ARADDR, M0_ARVALID, M0_RREADY,
        input  M1_ARADDR, M1_ARVALID, M1_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RVALID, M_AXI_RLAST,
        output M0_ARREADY, M0_RVALID, M1_ARREADY, M1_RVALID,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
    );

    // Requesters plus interconnect
    modport master (
        output M0_ARADDR, M0_ARVALID, M0_RREADY,
        output M1_ARADDR, M1_ARVALID, M1_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RVALID, M_AXI_RLAST,
        input  M0_ARREADY, M0_RVALID, M1_ARREADY, M1_RVALID,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
    );

endinterface

// File: rtl/vram_rd_arbiter_outstd.sv
// Saturating outstanding-burst counter for one requester, with full/empty flags.
module vram_arb_outstd
    import vram_arb_pkg::*;
#(
    parameter int C_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(C_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Simultaneous inc/dec cancel; protocol errors saturate instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != MAX)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign full_o  = (cnt_q == MAX);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/vram_rd_arbiter.sv
// Two-requester AXI read arbiter for the VRAM window; M0 has priority.
// Optional M1 anti-starvation: define ARB_STARVE_GUARD_EN.
module vram_rd_arbiter
    import vram_arb_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 29,
    parameter int C_MAX_OUTSTD = 4
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int C_STARVE_LIMIT = 8
`endif
) (
    input  logic             ACLK,
    input  logic             ARST,
    vram_rd_arbiter_if.slave bus,
    output logic             ARB_BUSY
);
    arb_state_e state_q;
    logic       grant_q, grant_d, arvalid_q;
    logic       elig0, elig1, force_aux;
    logic       ar_hs, rready, r_last_hs;
    logic [1:0] inc, dec, full, empty;

    assign elig0   = bus.M0_ARVALID && !full[0];
    assign elig1   = bus.M1_ARVALID && !full[1];
    assign grant_d = (elig0 && !force_aux) ? ID_DISP : ID_AUX;

`ifdef ARB_STARVE_GUARD_EN
    localparam int            SW         = $clog2(C_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(C_STARVE_LIMIT);

    logic [SW-1:0] starve_q;

    assign force_aux = (starve_q >= STARVE_MAX) && elig1;
`else
    assign force_aux = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q   <= IDLE;
            grant_q   <= ID_DISP;
            arvalid_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (elig0 || elig1) begin
                    state_q   <= ADDR;
                    grant_q   <= grant_d;
                    arvalid_q <= 1'b1;
`ifdef ARB_STARVE_GUARD_EN
                    // Only M0 grants issued while M1 is waiting count toward the limit
                    if (grant_d == ID_AUX)
                        starve_q <= '0;
                    else if (bus.M1_ARVALID && starve_q < STARVE_MAX)
                        starve_q <= starve_q + 1'b1;
`endif
                end
                ADDR: if (bus.M_AXI_ARREADY) begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_ARID    = grant_q;
    assign bus.M_AXI_ARADDR  = {VRAM_PREFIX, (grant_q == ID_AUX) ? bus.M1_ARADDR : bus.M0_ARADDR};

    assign ar_hs          = (state_q == ADDR) && bus.M_AXI_ARREADY;
    assign bus.M0_ARREADY = ar_hs && (grant_q == ID_DISP);
    assign bus.M1_ARREADY = ar_hs && (grant_q == ID_AUX);

    // R path is purely combinational steering by RID
    assign rready           = bus.M_AXI_RID ? bus.M1_RREADY : bus.M0_RREADY;
    assign bus.M_AXI_RREADY = rready;
    assign bus.M0_RVALID    = bus.M_AXI_RVALID && (bus.M_AXI_RID == ID_DISP);
    assign bus.M1_RVALID    = bus.M_AXI_RVALID && (bus.M_AXI_RID == ID_AUX);
    assign r_last_hs        = bus.M_AXI_RVALID && rready && bus.M_AXI_RLAST;

    for (genvar n = 0; n < 2; n++) begin : g_outstd
        assign inc[n] = ar_hs && (grant_q == 1'(n));
        assign dec[n] = r_last_hs && (bus.M_AXI_RID == 1'(n));

        vram_arb_outstd #(
            .C_MAX (C_MAX_OUTSTD)
        ) u_outstd (
            .clk_i   (ACLK),
            .rst_i   (ARST),
            .inc_i   (inc[n]),
            .dec_i   (dec[n]),
            .full_o  (full[n]),
            .empty_o (empty[n])
        );
    end

    assign ARB_BUSY = ~&empty;

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Randomized + directed bench for vram_rd_arbiter against a transaction-level model.
module tb_vram_rd_arbiter;
    localparam int AW   = 29;
    localparam int MAXO = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam int LIM  = 8;
`endif

    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    logic ARB_BUSY;

    vram_rd_arbiter_if #(.C_ADDR_WIDTH(AW)) bus();

    vram_rd_arbiter #(
        .C_ADDR_WIDTH (AW),
        .C_MAX_OUTSTD (MAXO)
    ) dut (
        .ACLK     (ACLK),
        .ARST     (ARST),
        .bus      (bus),
        .ARB_BUSY (ARB_BUSY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Stimulus state
    bit          arv[2];
    logic [AW-1:0] addr[2];
    bit          rrdy[2];
    bit          arrdy;
    bit          rv, rid;
    int          rrem;
    bit [1:0]    keep_ar;
    bit          auto_r, rand_on;
    int          r_rate = 50, max_len = 4, ar_rate = 30;

    // Reference model: expected AR channel, outstanding bursts, pending R bursts
    bit          m_arv, m_id;
    int          cnt[2];
    int          starve;
    int          q[2][$];
    int          grants[$];
    bit          hs[2];
    bit          racc;

    // Last sampled outputs, for directed checks
    logic [31:0] s_araddr;
    logic        s_arv, s_arid, s_ardy0, s_ardy1, s_rv0, s_rv1, s_rrdy, s_busy;

    task automatic drive();
        bus.M0_ARVALID    = arv[0];
        bus.M0_ARADDR     = addr[0];
        bus.M0_RREADY     = rrdy[0];
        bus.M1_ARVALID    = arv[1];
        bus.M1_ARADDR     = addr[1];
        bus.M1_RREADY     = rrdy[1];
        bus.M_AXI_ARREADY = arrdy;
        bus.M_AXI_RVALID  = rv;
        bus.M_AXI_RID     = rid;
        bus.M_AXI_RLAST   = (rrem == 1);
    endtask

    task automatic rand_stim();
        for (int n = 0; n < 2; n++) begin
            if (!arv[n] && $urandom_range(99) < ar_rate) begin
                arv[n]  = 1'b1;
                addr[n] = AW'($urandom);
            end
            rrdy[n] = ($urandom_range(99) < 70);
        end
        arrdy = ($urandom_range(99) < 60);
    endtask

    task automatic r_drive();
        int id;
        if (!rv && (q[0].size() + q[1].size()) > 0 && $urandom_range(99) < r_rate) begin
            if (q[0].size() > 0 && q[1].size() > 0) id = int'($urandom_range(1));
            else                                    id = (q[0].size() > 0) ? 0 : 1;
            rid  = 1'(id);
            rrem = q[id].pop_front();
            rv   = 1'b1;
        end
    endtask

    // One clock: check outputs against the model, advance the model, update stimulus.
    task automatic step();
        bit e0, e1, frc, pick, last;
        drive();
        @(negedge ACLK);
        s_arv = bus.M_AXI_ARVALID;   s_arid = bus.M_AXI_ARID;   s_araddr = bus.M_AXI_ARADDR;
        s_ardy0 = bus.M0_ARREADY;    s_ardy1 = bus.M1_ARREADY;
        s_rv0 = bus.M0_RVALID;       s_rv1 = bus.M1_RVALID;     s_rrdy = bus.M_AXI_RREADY;
        s_busy = ARB_BUSY;

        hs[0] = m_arv && arrdy && (m_id == 1'b0);
        hs[1] = m_arv && arrdy && (m_id == 1'b1);
        chk("arvalid", 32'(s_arv), 32'(m_arv));
        if (m_arv) begin
            chk("arid",   32'(s_arid), 32'(m_id));
            chk("araddr", s_araddr, {3'b001, addr[m_id]});
        end
        chk("m0_arready", 32'(s_ardy0), 32'(hs[0]));
        chk("m1_arready", 32'(s_ardy1), 32'(hs[1]));
        chk("m0_rvalid",  32'(s_rv0), 32'(rv && rid == 1'b0));
        chk("m1_rvalid",  32'(s_rv1), 32'(rv && rid == 1'b1));
        chk("rready",     32'(s_rrdy), 32'(rrdy[rid]));
        chk("busy",       32'(s_busy), 32'((cnt[0] + cnt[1]) != 0));

        racc = rv && rrdy[rid];
        last = racc && (rrem == 1);
        e0 = arv[0] && cnt[0] < MAXO;
        e1 = arv[1] && cnt[1] < MAXO;
        if (m_arv) begin
            if (arrdy) begin
                if (cnt[m_id] < MAXO) cnt[m_id]++;
                grants.push_back(int'(m_id));
                q[m_id].push_back(1 + int'($urandom_range(max_len - 1)));
                m_arv = 1'b0;
            end
        end else if (e0 || e1) begin
            frc = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            frc = (starve >= LIM) && e1;
`endif
            pick  = (e0 && !frc) ? 1'b0 : 1'b1;
`ifdef ARB_STARVE_GUARD_EN
            if (pick) starve = 0;
            else if (arv[1] && starve < LIM) starve++;
`endif
            m_arv = 1'b1;
            m_id  = pick;
        end
        if (last && cnt[rid] > 0) cnt[rid]--;

        @(posedge ACLK);
        #1;
        for (int n = 0; n < 2; n++) if (hs[n]) arv[n] = keep_ar[n];
        if (racc) begin
            rrem--;
            if (rrem == 0) rv = 1'b0;
        end
        if (rand_on) rand_stim();
        if (auto_r)  r_drive();
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int start = grants.size();
        int k = 0;
        while (grants.size() < start + n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(grants.size() - start), 32'(n));
    endtask

    task automatic do_reset();
        ARST = 1'b1;
        arv = '{0, 0}; rrdy = '{0, 0}; arrdy = 1'b0;
        rv = 1'b0; rid = 1'b0; rrem = 0;
        drive();
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        chk("rst_arvalid",   32'(bus.M_AXI_ARVALID), 32'd0);
        chk("rst_busy",      32'(ARB_BUSY), 32'd0);
        chk("rst_m0_arready", 32'(bus.M0_ARREADY), 32'd0);
        @(posedge ACLK);
        #1;
        ARST  = 1'b0;
        m_arv = 1'b0; m_id = 1'b0; cnt = '{0, 0}; starve = 0;
        q[0].delete(); q[1].delete();
    endtask

    initial begin
        int g, k;
        keep_ar = 2'b00; auto_r = 1'b0; rand_on = 1'b0;
        addr = '{default: '0};
        do_reset();

        // Single M0 request
        arv[0] = 1'b1; addr[0] = 29'h0001000;
        step();
        arrdy = 1'b1;
        step();
        chk("t1_arvalid", 32'(s_arv), 32'd1);
        chk("t1_araddr",  s_araddr, 32'h2000_1000);
        chk("t1_arid",    32'(s_arid), 32'd0);
        chk("t1_m0_ready", 32'(s_ardy0), 32'd1);
        arrdy = 1'b0;
        step();
        chk("t1_ready_pulse", 32'(s_ardy0), 32'd0);

        // Simultaneous requests: M0 first, then M1
        arv = '{1, 1}; addr[0] = AW'($urandom); addr[1] = AW'($urandom); arrdy = 1'b1;
        g = grants.size();
        wait_grants(2, 20, "t2_grants");
        if (grants.size() >= g + 2) begin
            chk("t2_first",  32'(grants[g]), 32'd0);
            chk("t2_second", 32'(grants[g+1]), 32'd1);
        end

        // Fill M0, confirm it blocks while M1 still gets through, then unblock
        do_reset();
        keep_ar = 2'b01; arv[0] = 1'b1; arrdy = 1'b1;
        wait_grants(4, 30, "t3_fill");
        g = grants.size();
        repeat (6) step();
        chk("t3_m0_blocked", 32'(grants.size()), 32'(g));
        keep_ar = 2'b00; arv[1] = 1'b1;
        wait_grants(1, 10, "t3_m1_grant");
        if (grants.size() > g) chk("t3_m1_id", 32'(grants[g]), 32'd1);
        rv = 1'b1; rid = 1'b0; rrem = 1; rrdy[0] = 1'b1;
        step();
        g = grants.size();
        wait_grants(1, 10, "t3_unblock");
        if (grants.size() > g) chk("t3_unblock_id", 32'(grants[g]), 32'd0);

        // R routing with RID=1 stalled, then RID=0 accepted
        arrdy = 1'b0; rv = 1'b1; rid = 1'b1; rrem = 2; rrdy[0] = 1'b1; rrdy[1] = 1'b0;
        step();
        chk("t4_rready_stall", 32'(s_rrdy), 32'd0);
        chk("t4_m1_rvalid", 32'(s_rv1), 32'd1);
        chk("t4_m0_rvalid", 32'(s_rv0), 32'd0);
        rid = 1'b0;
        step();
        chk("t4b_rready", 32'(s_rrdy), 32'd1);
        chk("t4b_m0_rvalid", 32'(s_rv0), 32'd1);
        rv = 1'b0; rrem = 0;

        // Same-cycle ARREADY and RLAST for M0 leave its count unchanged
        do_reset();
        arv[0] = 1'b1; arrdy = 1'b1;
        wait_grants(1, 10, "t5_first");
        arrdy = 1'b0; arv[0] = 1'b1;
        k = 0;
        while (!m_arv && k < 10) begin step(); k++; end
        chk("t5_addr_phase", 32'(m_arv), 32'd1);
        arrdy = 1'b1; rv = 1'b1; rid = 1'b0; rrem = 1; rrdy[0] = 1'b1;
        step();
        arrdy = 1'b0;
        step();
        chk("t5_busy_held", 32'(s_busy), 32'd1);
        rv = 1'b1; rid = 1'b0; rrem = 1;
        step();
        step();
        chk("t5_busy_clear", 32'(s_busy), 32'd0);

        // M0 saturating the bus while M1 waits
        do_reset();
        keep_ar = 2'b11; arv = '{1, 1}; arrdy = 1'b1; rrdy = '{1, 1};
        auto_r = 1'b1; r_rate = 100; max_len = 1;
        g = grants.size();
        wait_grants(9, 60, "t6_grants");
        if (grants.size() >= g + 9) begin
            chk("t6_first", 32'(grants[g]), 32'd0);
`ifdef ARB_STARVE_GUARD_EN
            chk("t6_ninth", 32'(grants[g+8]), 32'd1);
`else
            chk("t6_ninth", 32'(grants[g+8]), 32'd0);
`endif
        end

        // Random traffic, a reset with bursts in flight, then slow R to hit full
        keep_ar = 2'b00;
        do_reset();
        rand_on = 1'b1; auto_r = 1'b1; r_rate = 40; max_len = 4;
        repeat (1500) step();
        do_reset();
        repeat (1500) step();
        r_rate = 5;
        repeat (1000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
